// File: rtl/aftab_restoring_divider_pkg.sv
// Shared AAU defines: divider FSM encodings and a ceil(log2) helper.
// Imported by the restoring divider and its iteration counter.
package aftab_restoring_divider_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INIT      = 3'd1,
        DIVIDE    = 3'd2,
        CORRECT   = 3'd3,
        COMPLETED = 3'd4
    } div_state_e;

    // Smallest r with 2**r >= n.
    function automatic int log2_ceil(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/aftab_counter.sv
// Loadable up-counter with carry-out on the all-ones count.
// Ports: clk, rst (sync, high), ld/init load, inc enable, co carry-out.
module aftab_counter #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ld,
    input  logic         inc,
    input  logic [W-1:0] init,
    output logic         co
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (ld) begin
            cnt <= init;
        end else if (inc) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign co = inc & (&cnt);

endmodule

// File: rtl/aftab_restoring_divider.sv
// Multi-cycle restoring divider, signed or unsigned, one bit per cycle.
// Ports: clk, rst, startDiv, signedOp, dividend, divisor in;
// quotient, remainder, done (pulse), divByZero out.
module aftab_restoring_divider
    import aftab_restoring_divider_pkg::*;
#(
    parameter int size = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            startDiv,
    input  logic            signedOp,
    input  logic [size-1:0] dividend,
    input  logic [size-1:0] divisor,
    output logic [size-1:0] quotient,
    output logic [size-1:0] remainder,
    output logic            done,
    output logic            divByZero
);

    localparam int CW = log2_ceil(size);
    // Preload so the counter wraps after exactly size increments.
    localparam logic [CW-1:0] CNT_INIT = CW'((1 << CW) - size);

    div_state_e state, nstate;

    logic [size-1:0] a_raw, b_raw;
    logic [size-1:0] a_mag, b_mag;
    logic [size-1:0] q_r, d_r;
    logic [size:0]   r_r;
    logic [size+1:0] trial;
    logic            sgn_r, qneg_r, rneg_r;
    logic            ld_cnt, inc_cnt, co;

    aftab_counter #(.W(CW)) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .ld   (ld_cnt),
        .inc  (inc_cnt),
        .init (CNT_INIT),
        .co   (co)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nstate;
        end
    end

    always_comb begin
        nstate  = state;
        ld_cnt  = 1'b0;
        inc_cnt = 1'b0;
        done    = 1'b0;
        unique case (state)
            IDLE: begin
                if (startDiv) begin
                    nstate = INIT;
                end
            end
            INIT: begin
                ld_cnt = 1'b1;
                nstate = DIVIDE;
            end
            DIVIDE: begin
                inc_cnt = 1'b1;
                if (co) begin
                    nstate = CORRECT;
                end
            end
            CORRECT: begin
                nstate = COMPLETED;
            end
            COMPLETED: begin
                done   = 1'b1;
                nstate = IDLE;
            end
            default: begin
                nstate = IDLE;
            end
        endcase
    end

    assign a_mag = (sgn_r && a_raw[size-1]) ? -a_raw : a_raw;
    assign b_mag = (sgn_r && b_raw[size-1]) ? -b_raw : b_raw;

    // R stays below D, so the top bit of R is always zero; the extra
    // width of trial just carries the borrow of shifted R minus D.
    assign trial = {r_r, q_r[size-1]} - {2'b00, d_r};

    always_ff @(posedge clk) begin
        if (rst) begin
            a_raw     <= '0;
            b_raw     <= '0;
            sgn_r     <= 1'b0;
            q_r       <= '0;
            d_r       <= '0;
            r_r       <= '0;
            qneg_r    <= 1'b0;
            rneg_r    <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            divByZero <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (startDiv) begin
                        a_raw <= dividend;
                        b_raw <= divisor;
                        sgn_r <= signedOp;
                    end
                end
                INIT: begin
                    q_r       <= a_mag;
                    d_r       <= b_mag;
                    r_r       <= '0;
                    qneg_r    <= a_raw[size-1] ^ b_raw[size-1];
                    rneg_r    <= a_raw[size-1];
                    divByZero <= (b_raw == '0);
                end
                DIVIDE: begin
                    if (!trial[size+1]) begin
                        r_r <= trial[size:0];
                        q_r <= {q_r[size-2:0], 1'b1};
                    end else begin
                        r_r <= {r_r[size-1:0], q_r[size-1]};
                        q_r <= {q_r[size-2:0], 1'b0};
                    end
                end
                CORRECT: begin
                    if (divByZero) begin
                        quotient  <= '1;
                        remainder <= a_raw;
                    end else begin
                        quotient  <= (sgn_r && qneg_r) ? -q_r : q_r;
                        remainder <= (sgn_r && rneg_r) ?
                                     -r_r[size-1:0] : r_r[size-1:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aftab_restoring_divider.sv
// Directed bench for the restoring divider with a result scoreboard.
// Covers latency, sign handling, divide-by-zero, overflow, reset abort.
module tb_aftab_restoring_divider;
    import aftab_restoring_divider_pkg::*;

    localparam int W = 32;
    localparam logic [W-1:0] MINV = 32'h8000_0000;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         startDiv;
    logic         signedOp;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         done;
    logic         divByZero;

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    aftab_restoring_divider #(.size(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .startDiv  (startDiv),
        .signedOp  (signedOp),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .done      (done),
        .divByZero (divByZero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a,
                                   input logic [W-1:0] b, input logic s);
        exp_t e;
        e.z = (b == '0);
        if (b == '0) begin
            e.q = '1;
            e.r = a;
        end else if (s && a == MINV && b == '1) begin
            e.q = a;
            e.r = '0;
        end else if (s) begin
            e.q = $signed(a) / $signed(b);
            e.r = $signed(a) % $signed(b);
        end else begin
            e.q = a / b;
            e.r = a % b;
        end
        return e;
    endfunction

    // Count edges until done; operands are scrambled right after the
    // sampling edge sc so later changes must not leak into the result.
    task automatic wait_done(input int sc, input bit hold,
                             output int n, output bit found);
        found = 1'b0;
        n = 0;
        for (int i = 1; i <= 80; i++) begin
            @(posedge clk);
            #1;
            if (i == 1 && !hold) startDiv = 1'b0;
            if (i == sc) begin
                dividend = $urandom;
                divisor  = $urandom;
                signedOp = 1'($urandom_range(0, 1));
            end
            if (done) begin
                n = i;
                found = 1'b1;
                return;
            end
        end
    endtask

    task automatic check_result(input string tag, input int n,
                                input bit found, input int lat);
        exp_t e;
        chk({tag, "_done_seen"}, 32'(found), 32'd1);
        if (sb.size() == 0) begin
            chk({tag, "_sb_nonempty"}, 32'(sb.size()), 32'd1);
            return;
        end
        e = sb.pop_front();
        if (!found) return;
        chk({tag, "_latency"}, n, lat);
        chk({tag, "_q"}, quotient, e.q);
        chk({tag, "_r"}, remainder, e.r);
        chk({tag, "_dbz"}, 32'(divByZero), 32'(e.z));
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic s);
        int n;
        bit found;
        dividend = a;
        divisor  = b;
        signedOp = s;
        startDiv = 1'b1;
        sb.push_back(model(a, b, s));
        wait_done(1, 1'b0, n, found);
        check_result(tag, n, found, 35);
        @(posedge clk);
        #1;
        chk({tag, "_pulse_len"}, 32'(done), 32'd0);
    endtask

    initial begin
        int n;
        bit found;
        int seen;
        rst      = 1'b1;
        startDiv = 1'b0;
        signedOp = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_state", 32'(dut.state), 32'(IDLE));
        chk("rst_q", quotient, 32'd0);
        chk("rst_r", remainder, 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_dbz", 32'(divByZero), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_op("u100_7", 32'd100, 32'd7, 1'b0);
        run_op("s_m100_7", -32'sd100, 32'd7, 1'b1);
        run_op("s_100_m7", 32'd100, -32'sd7, 1'b1);
        run_op("u_dbz", 32'h1234, 32'd0, 1'b0);
        run_op("s_dbz", 32'h1234, 32'd0, 1'b1);
        run_op("s_dbz_neg", 32'hFFFF_FF00, 32'd0, 1'b1);
        run_op("s_ovf", MINV, 32'hFFFF_FFFF, 1'b1);
        run_op("u_min_ff", MINV, 32'hFFFF_FFFF, 1'b0);
        run_op("s_m7_m2", -32'sd7, -32'sd2, 1'b1);
        run_op("u_big", 32'hFFFF_FFFF, 32'd1, 1'b0);
        run_op("u_small", 32'd3, 32'd9, 1'b0);
        for (int k = 0; k < 4; k++) begin
            run_op("rand", $urandom, 32'($urandom_range(1, 100000)),
                   1'($urandom_range(0, 1)));
        end

        // Reset during the 10th DIVIDE cycle aborts the operation.
        dividend = 32'hFFFF;
        divisor  = 32'd3;
        signedOp = 1'b0;
        startDiv = 1'b1;
        @(posedge clk);
        #1;
        startDiv = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("abort_in_divide", 32'(dut.state), 32'(DIVIDE));
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort_state", 32'(dut.state), 32'(IDLE));
        chk("abort_q", quotient, 32'd0);
        chk("abort_r", remainder, 32'd0);
        chk("abort_dbz", 32'(divByZero), 32'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) seen++;
            @(posedge clk);
            #1;
        end
        chk("abort_no_done", seen, 0);
        run_op("u7_2", 32'd7, 32'd2, 1'b0);

        // startDiv held high: back-to-back operations.
        dividend = 32'd1000;
        divisor  = 32'd33;
        signedOp = 1'b0;
        startDiv = 1'b1;
        sb.push_back(model(dividend, divisor, signedOp));
        wait_done(1, 1'b1, n, found);
        check_result("b2b0", n, found, 35);
        dividend = -32'sd5000;
        divisor  = 32'd77;
        signedOp = 1'b1;
        sb.push_back(model(dividend, divisor, signedOp));
        wait_done(2, 1'b1, n, found);
        check_result("b2b1", n, found, 36);
        dividend = 32'hDEAD_BEEF;
        divisor  = 32'h1234;
        signedOp = 1'b0;
        sb.push_back(model(dividend, divisor, signedOp));
        wait_done(2, 1'b1, n, found);
        startDiv = 1'b0;
        check_result("b2b2", n, found, 36);
        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
